// File: rtl/bayer_seq_pkg.sv
// Shared types and constants for the Bayer reorder-buffer sequencer.
// The buffer drains in fixed 32-beat bursts.
package bayer_seq_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam int BURST_BEATS = 32;
  localparam int BURST_LOG2  = 5;

endpackage

// File: rtl/bayer_seq_ctrl.sv
// Frame sequencer for the Bayer reorder buffer: gates input beats,
// maps backpressure to pause, drives flush and per-frame buffer reset.
module bayer_seq_ctrl
  import bayer_seq_pkg::*;
#(
  parameter int CNT_W  = 24,
  parameter int FCNT_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CNT_W-1:0]  cfg_frame_beats,
  input  logic              cfg_continuous,
  input  logic              start,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              dst_ready,
  output logic              dst_valid,
  output logic              dst_last,
  output logic              rs_input_valid,
  output logic              rs_pause,
  output logic              rs_end_in,
  output logic              rs_rst,
  input  logic              rs_output_valid,
  input  logic              rs_end_out,
  output logic              busy,
  output logic              frame_done,
  output logic              err_cfg,
  output logic              err_count,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  beats_q, beats_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              cont_q, cont_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              ecfg_q, ecfg_d;
  logic              ecnt_q, ecnt_d;

  logic             cfg_ok;
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] last_idx;

  assign cfg_ok = (cfg_frame_beats != '0) &&
    (cfg_frame_beats[BURST_LOG2-1:0] == '0);
  assign last_idx = beats_q - CNT_W'(1);

  assign rs_pause       = ~dst_ready;
  assign src_ready      = (state_q == RUN) & dst_ready;
  assign rs_input_valid = src_valid & src_ready;
  assign rs_end_in      = (state_q == FLUSH);
  assign rs_rst         = (state_q == CLEAR);
  assign dst_valid      = rs_output_valid &
    ((state_q == RUN) | (state_q == FLUSH));
  assign dst_last  = dst_valid & (out_cnt_q == last_idx);
  assign busy      = (state_q != IDLE);
  assign frame_done = done_q;
  assign err_cfg   = ecfg_q;
  assign err_count = ecnt_q;
  assign frame_cnt = fcnt_q;

  assign in_fire  = rs_input_valid;
  assign out_fire = dst_valid & dst_ready;

  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    cont_d    = cont_q;
    pend_d    = pend_q;
    fcnt_d    = fcnt_q;
    ecfg_d    = ecfg_q;
    ecnt_d    = ecnt_q;
    done_d    = 1'b0;
    in_cnt_d  = in_cnt_q + CNT_W'(in_fire);
    out_cnt_d = out_cnt_q + CNT_W'(out_fire);
    unique case (state_q)
      CLEAR: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = IDLE;
      end
      IDLE: begin
        if (start || pend_q) begin
          pend_d = 1'b0;
          if (cfg_ok) begin
            state_d = RUN;
            beats_d = cfg_frame_beats;
            cont_d  = cfg_continuous;
          end else begin
            ecfg_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_fire && (in_cnt_q == last_idx)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (rs_end_out) begin
          state_d = CLEAR;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + FCNT_W'(1);
          pend_d  = cont_q;
          if (out_cnt_q != beats_q) begin
            ecnt_d = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= CLEAR;
      beats_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      fcnt_q    <= '0;
      cont_q    <= 1'b0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      ecfg_q    <= 1'b0;
      ecnt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beats_q   <= beats_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      fcnt_q    <= fcnt_d;
      cont_q    <= cont_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      ecfg_q    <= ecfg_d;
      ecnt_q    <= ecnt_d;
    end
  end

endmodule

// File: doc/bayer_seq_ctrl.md
# bayer_seq_ctrl

Frame-level sequencer for the Bayer-to-sequence reorder buffer in the LJPEG-1992 pipeline. It gates upstream pixel beats into the buffer and converts downstream backpressure into the buffer's pause input. At the end of each frame it drives the buffer's 32-beat flush, then resets the buffer for the next frame. It carries control only: the 192-bit pixel data is wired directly between the source, the buffer and the sink.

## Interface
Parameters:
- CNT_W, 24, width of the per-frame beat counters (`cfg_frame_beats`, input count, output count).
- FCNT_W, 16, width of the completed-frame counter.

Ports (`name  direction  width  meaning`):
- `sys_clk`  in  1  single clock.
- `sys_rst_n`  in  1  reset, asynchronous and active-low.
- `cfg_frame_beats`  in  CNT_W  input beats (16 pixels each) per frame; latched on start.
- `cfg_continuous`  in  1  restart automatically after each frame; latched on start.
- `start`  in  1  pulse; begins a frame when in IDLE.
- `src_valid`  in  1  upstream has a beat.
- `src_ready`  out  1  upstream beat accepted this cycle when high with `src_valid`.
- `dst_ready`  in  1  downstream can take a beat.
- `dst_valid`  out  1  buffer output beat valid.
- `dst_last`  out  1  final output beat of the frame.
- `rs_input_valid`  out  1  to buffer `input_valid`.
- `rs_pause`  out  1  to buffer `pause_signal`.
- `rs_end_in`  out  1  to buffer `end_in`.
- `rs_rst`  out  1  to buffer `sys_rst` (active-high, synchronous).
- `rs_output_valid`  in  1  from buffer `output_valid`.
- `rs_end_out`  in  1  from buffer `end_out` (sticky until `rs_rst`).
- `busy`  out  1  state is not IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `err_cfg`  out  1  sticky; a start was rejected because of a bad configuration.
- `err_count`  out  1  sticky; a frame's output beat count did not equal `cfg_frame_beats`.
- `frame_cnt`  out  FCNT_W  number of completed frames; wraps.

## Operation
- States:
  - CLEAR: reset state; asserts `rs_rst`.
  - IDLE: waits for `start` or a pending restart.
  - RUN: passes input beats to the buffer.
  - FLUSH: drives `rs_end_in` until the buffer reports `end_out`.
- Transitions:
  - CLEAR→IDLE unconditionally after 1 cycle.
  - IDLE→RUN on `start` or `cont_pending`.
    - The start is rejected if `cfg_frame_beats` is 0 or its bits [4:0] are nonzero (not a multiple of 32). A rejected start sets `err_cfg` and the block stays in IDLE.
    - On RUN entry: latch `frame_beats_q` and `cont_q`, clear `cont_pending`.
  - RUN→FLUSH on the accepted beat where `in_cnt == frame_beats_q-1`.
  - FLUSH→CLEAR when `rs_end_out` is 1. On this transition:
    - pulse `frame_done`;
    - increment `frame_cnt`;
    - set `err_count` if `out_cnt != frame_beats_q`;
    - set `cont_pending = cont_q`.
- Combinational outputs:
  - `rs_pause = ~dst_ready`.
  - `src_ready = (state==RUN) & dst_ready`.
  - `rs_input_valid = src_valid & src_ready`.
  - `rs_end_in = (state==FLUSH)`.
  - `rs_rst = (state==CLEAR)`.
  - `dst_valid = rs_output_valid & (state==RUN | state==FLUSH)`.
  - `dst_last = dst_valid & (out_cnt == frame_beats_q-1)`.
- Counters:
  - `in_cnt` increments on each accepted input beat.
  - `out_cnt` increments on each `dst_valid & dst_ready`.
  - Both are cleared in CLEAR and are CNT_W bits wide with no saturation.
- `start` is ignored outside IDLE.
- Errors clear only on reset.

## Timing
- Reset values:
  - state = CLEAR, so `rs_rst=1` and `busy=1` during reset;
  - `src_ready`, `dst_valid`, `dst_last`, `rs_input_valid`, `rs_end_in`, `frame_done`, `err_cfg`, `err_count` = 0;
  - `frame_cnt` = 0;
  - `rs_pause = ~dst_ready`.
- Reset release: first edge moves CLEAR→IDLE.
- Start: `start` at edge N means RUN from N+1, and `src_ready` can be high in cycle N+1.
- Input path: combinational from `dst_ready`. A beat accepted at edge N is written into the buffer at N+1.
- Output latency is fixed by the buffer:
  - the first 32 accepted beats produce no output;
  - output beat k of the frame appears once input beat k+32 is accepted, or during FLUSH.
- Flush: at least 33 unpaused FLUSH cycles (32 output beats, then `end_out`).
- Frame end: `frame_done` is high in the cycle state is CLEAR. The next RUN starts no earlier than 2 cycles after `rs_end_out`.
- `dst_ready` low holds the buffer frozen. `dst_valid` and data stay stable until `dst_ready` returns.
- Reset mid-operation: state returns to CLEAR asynchronously and `rs_rst` is 1 immediately; partial-frame counters are discarded.

## Structure
- Package `bayer_seq_pkg`:
  - `state_t` enum {CLEAR, IDLE, RUN, FLUSH};
  - constant `BURST_BEATS = 32`;
  - constant `BURST_LOG2 = 5`.
- Single module, no sub-modules.
- The top level instantiates this block beside the buffer and wires data paths directly.

## Test plan
- Basic frame: `cfg_frame_beats=64`, `dst_ready=1`, `src_valid=1`, `start` pulse → exactly 64 `dst_valid` beats, `dst_last` on the 64th, one `frame_done`, `frame_cnt=1`, `err_count=0`, one `rs_rst` cycle.
- Backpressure: as the basic frame, but `dst_ready` toggles with a 3-low/2-high pattern → `src_ready` is 0 whenever `dst_ready` is 0, no beat is lost or duplicated (pixel checker against the buffer reference model), 64 outputs.
- Bad configuration: `start` with `cfg_frame_beats=48`, then with 0 → `err_cfg=1`, state stays IDLE, `busy=0`, no `rs_input_valid`.
- Continuous mode: `cfg_continuous=1`, 32 beats per frame, a single `start` → two consecutive frames with no further `start`, `frame_cnt=2`, `rs_rst` pulsed between them.
- Reset mid-frame: `sys_rst_n` low after 40 of 64 beats → immediate `rs_rst=1`, outputs at reset values; a following clean 64-beat frame passes.
- Count error: force `rs_end_out=1` early, after 10 output beats → `err_count=1`, `frame_done` pulses, state goes to CLEAR.
